// File: rtl/mipi_rx_ctrl_pkg.sv
// Shared definitions for the MIPI RX lane controller: lane states, LP codes, leader word, slip limit.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package mipi_rx_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_STOP    = 3'd1,
      ST_HS_RQST = 3'd2,
      ST_HS_PREP = 3'd3,
      ST_SYNC    = 3'd4,
      ST_DATA    = 3'd5,
      ST_ERR     = 3'd6
   } lane_state_e;

   localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hB8;
   localparam logic [2:0] MAX_SLIP          = 3'd7;

   // LP line codes, written as {DP, DN}
   localparam logic [1:0] LP_00 = 2'b00;
   localparam logic [1:0] LP_01 = 2'b01;
   localparam logic [1:0] LP_10 = 2'b10;
   localparam logic [1:0] LP_11 = 2'b11;

endpackage

// File: rtl/mipi_lp_sync.sv
// LP line synchronizer: 2-FF metastability chain plus a filter that accepts a code seen on 2 consecutive samples.
// Latency: 4 clocks from a stable line code to lp_code.
// Backpressure: none; free-running sampler.
module mipi_lp_sync
   import mipi_rx_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       lp_dp,
   input  logic       lp_dn,
   output logic [1:0] lp_code
);

   logic [1:0] meta;
   logic [1:0] sync;
   logic [1:0] prev;

   // Synchronize both lines together; resetting to LP-00 means a line already at LP-11 must still be seen twice
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta    <= LP_00;
         sync    <= LP_00;
         prev    <= LP_00;
         lp_code <= LP_00;
      end else begin
         meta <= {lp_dp, lp_dn};
         sync <= meta;
         prev <= sync;
         if (sync == prev) begin
            lp_code <= sync;
         end
      end
   end

endmodule

// File: rtl/mipi_rx_lane_ctrl.sv
// MIPI D-PHY RX lane controller: LP handshake, HS settle, leader search with bit-slip, payload forwarding, EOT detect.
// Latency: payload word to RX_DATA/RX_DATA_VALID is 1 clock; LP codes act ~5 clocks after the lines settle.
// Backpressure: none; HS words are consumed as they arrive and the downstream must accept every strobe.
module mipi_rx_lane_ctrl
   import mipi_rx_ctrl_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 6,
   parameter int unsigned SYNC_TIMEOUT  = 64,
   parameter int unsigned EOT_TIMEOUT   = 16,
   parameter logic [7:0]  SYNC_WORD     = DEFAULT_SYNC_WORD
) (
   input  logic       CLK_IN,
   input  logic       RST,
   input  logic       PLL_LOCK,
   input  logic       LP_RX_DP,
   input  logic       LP_RX_DN,
   input  logic [7:0] HS_RX_DATA,
   input  logic       HS_RXD_VALID,
   output logic       HS_EN,
   output logic       LP_EN,
   output logic       RX_TERM_EN,
   output logic       BITSLIP_ADJ,
   output logic [7:0] RX_DATA,
   output logic       RX_DATA_VALID,
   output logic       SOT,
   output logic       EOT,
   output logic       SOT_ERR,
   output logic [2:0] LANE_STATE
);

   // One shared timer: settle count in HS_PREP, dwell in SYNC, idle clocks in DATA
   localparam logic [9:0] SETTLE_LAST = 10'(SETTLE_CYCLES - 1);
   localparam logic [9:0] SYNC_LAST   = 10'(SYNC_TIMEOUT - 1);
   localparam logic [9:0] EOT_LAST    = 10'(EOT_TIMEOUT - 1);

   lane_state_e state;
   lane_state_e state_nxt;
   logic [1:0]  lp_code;
   logic [9:0]  tmr;
   logic [2:0]  slip_cnt;
   logic        skip;
   logic        cmp_vld;
   logic        slip_evt;
   logic        sot_evt;
   logic        eot_evt;
   logic        fwd_vld;

   mipi_lp_sync u_lp_sync (
      .clk     (CLK_IN),
      .rst_n   (RST),
      .lp_dp   (LP_RX_DP),
      .lp_dn   (LP_RX_DN),
      .lp_code (lp_code)
   );

   // A word right after a slip is misaligned garbage, so it is not compared
   assign cmp_vld    = HS_RXD_VALID && !skip;
   assign fwd_vld    = PLL_LOCK && (state == ST_DATA) && HS_RXD_VALID;
   assign LANE_STATE = state;

   // Next-state and event decode; losing PLL lock overrides everything and raises no event
   always_comb begin
      state_nxt = state;
      slip_evt  = 1'b0;
      sot_evt   = 1'b0;
      eot_evt   = 1'b0;
      case (state)
         ST_IDLE:    if (lp_code == LP_11) state_nxt = ST_STOP;
         ST_STOP:    if (lp_code == LP_01) state_nxt = ST_HS_RQST;
         ST_HS_RQST: begin
            case (lp_code)
               LP_00:   state_nxt = ST_HS_PREP;
               LP_11:   state_nxt = ST_STOP;
               LP_10:   state_nxt = ST_ERR;
               default: state_nxt = ST_HS_RQST;
            endcase
         end
         ST_HS_PREP: if (tmr == SETTLE_LAST) state_nxt = ST_SYNC;
         ST_SYNC: begin
            // A leader match in the timeout clock still wins
            if (cmp_vld && (HS_RX_DATA == SYNC_WORD)) begin
               state_nxt = ST_DATA;
               sot_evt   = 1'b1;
            end else if (tmr == SYNC_LAST) begin
               state_nxt = ST_ERR;
            end else if (cmp_vld) begin
               if (slip_cnt < MAX_SLIP) slip_evt  = 1'b1;
               else                     state_nxt = ST_ERR;
            end
         end
         ST_DATA: begin
            if ((lp_code == LP_11) || (!HS_RXD_VALID && (tmr == EOT_LAST))) begin
               state_nxt = ST_IDLE;
               eot_evt   = 1'b1;
            end
         end
         default:    state_nxt = ST_IDLE;
      endcase
      if (!PLL_LOCK) begin
         state_nxt = ST_IDLE;
         slip_evt  = 1'b0;
         sot_evt   = 1'b0;
         eot_evt   = 1'b0;
      end
   end

   // State, shared timer and leader-search bookkeeping
   always_ff @(posedge CLK_IN or negedge RST) begin
      if (!RST) begin
         state    <= ST_IDLE;
         tmr      <= '0;
         slip_cnt <= '0;
         skip     <= 1'b0;
      end else begin
         state <= state_nxt;
         if ((state_nxt != state) || ((state == ST_DATA) && HS_RXD_VALID)) tmr <= '0;
         else                                                              tmr <= tmr + 10'd1;
         if ((state_nxt == ST_SYNC) && (state != ST_SYNC)) begin
            slip_cnt <= '0;
            skip     <= 1'b0;
         end else if (slip_evt) begin
            slip_cnt <= slip_cnt + 3'd1;
            skip     <= 1'b1;
         end else if ((state == ST_SYNC) && HS_RXD_VALID && skip) begin
            skip <= 1'b0;
         end
      end
   end

   // Registered outputs decoded from the next state so they line up with LANE_STATE
   always_ff @(posedge CLK_IN or negedge RST) begin
      if (!RST) begin
         HS_EN         <= 1'b0;
         LP_EN         <= 1'b0;
         RX_TERM_EN    <= 1'b0;
         BITSLIP_ADJ   <= 1'b0;
         SOT           <= 1'b0;
         EOT           <= 1'b0;
         SOT_ERR       <= 1'b0;
         RX_DATA_VALID <= 1'b0;
         RX_DATA       <= 8'h00;
      end else begin
         LP_EN         <= PLL_LOCK && (state_nxt inside {ST_IDLE, ST_STOP, ST_HS_RQST});
         HS_EN         <= state_nxt inside {ST_HS_PREP, ST_SYNC, ST_DATA};
         RX_TERM_EN    <= state_nxt inside {ST_HS_PREP, ST_SYNC, ST_DATA};
         BITSLIP_ADJ   <= slip_evt;
         SOT           <= sot_evt;
         EOT           <= eot_evt;
         SOT_ERR       <= (state_nxt == ST_ERR);
         RX_DATA_VALID <= fwd_vld;
         if (fwd_vld) begin
            RX_DATA <= HS_RX_DATA;
         end
      end
   end

endmodule

// File: tb/tb_mipi_rx_lane_ctrl.sv
// Self-checking bench for mipi_rx_lane_ctrl: scoreboard of expected lane events vs. a monitor on the outputs.
// Latency: n/a.
// Backpressure: n/a.
module tb_mipi_rx_lane_ctrl;

   localparam int unsigned SETTLE = 6;
   localparam int unsigned SYNC_TO = 64;
   localparam int unsigned EOT_TO = 16;
   localparam logic [7:0]  SW = 8'hB8;

   localparam int EV_DATA = 0;
   localparam int EV_SLIP = 1;
   localparam int EV_SOT  = 2;
   localparam int EV_EOT  = 3;
   localparam int EV_ERR  = 4;

   typedef struct {
      int         kind;
      logic [7:0] dat;
   } ev_t;

   logic       clk = 1'b0;
   logic       RST;
   logic       PLL_LOCK;
   logic       LP_RX_DP;
   logic       LP_RX_DN;
   logic [7:0] HS_RX_DATA;
   logic       HS_RXD_VALID;
   logic       HS_EN;
   logic       LP_EN;
   logic       RX_TERM_EN;
   logic       BITSLIP_ADJ;
   logic [7:0] RX_DATA;
   logic       RX_DATA_VALID;
   logic       SOT;
   logic       EOT;
   logic       SOT_ERR;
   logic [2:0] LANE_STATE;

   int         n_chk = 0;
   int         n_err = 0;
   ev_t        exp_q[$];
   logic [7:0] pay_q[$];

   mipi_rx_lane_ctrl #(
      .SETTLE_CYCLES (SETTLE),
      .SYNC_TIMEOUT  (SYNC_TO),
      .EOT_TIMEOUT   (EOT_TO),
      .SYNC_WORD     (SW)
   ) dut (
      .CLK_IN        (clk),
      .RST           (RST),
      .PLL_LOCK      (PLL_LOCK),
      .LP_RX_DP      (LP_RX_DP),
      .LP_RX_DN      (LP_RX_DN),
      .HS_RX_DATA    (HS_RX_DATA),
      .HS_RXD_VALID  (HS_RXD_VALID),
      .HS_EN         (HS_EN),
      .LP_EN         (LP_EN),
      .RX_TERM_EN    (RX_TERM_EN),
      .BITSLIP_ADJ   (BITSLIP_ADJ),
      .RX_DATA       (RX_DATA),
      .RX_DATA_VALID (RX_DATA_VALID),
      .SOT           (SOT),
      .EOT           (EOT),
      .SOT_ERR       (SOT_ERR),
      .LANE_STATE    (LANE_STATE)
   );

   always #5 clk = ~clk;

   function automatic string kname(int k);
      case (k)
         EV_DATA: return "RX_DATA_VALID";
         EV_SLIP: return "BITSLIP_ADJ";
         EV_SOT:  return "SOT";
         EV_EOT:  return "EOT";
         default: return "SOT_ERR";
      endcase
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(int kind, logic [7:0] d);
      ev_t e;
      e.kind = kind;
      e.dat  = d;
      exp_q.push_back(e);
   endtask

   // Monitor side of the scoreboard: each output event pops one expectation
   task automatic mon_pop(int kind, logic [7:0] d);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_chk++;
         n_err++;
         $display("FAIL unexpected %s: data %0h, no event expected (t=%0t)", kname(kind), d, $time);
      end else begin
         e = exp_q.pop_front();
         chk({"event order, saw ", kname(kind)}, kind, e.kind);
         if (kind == EV_DATA) chk("RX_DATA payload", d, e.dat);
      end
   endtask

   always @(negedge clk) begin
      if (RX_DATA_VALID) mon_pop(EV_DATA, RX_DATA);
      if (BITSLIP_ADJ)   mon_pop(EV_SLIP, 8'h00);
      if (SOT)           mon_pop(EV_SOT, 8'h00);
      if (EOT)           mon_pop(EV_EOT, 8'h00);
      if (SOT_ERR)       mon_pop(EV_ERR, 8'h00);
   end

   task automatic lp(logic [1:0] c);
      LP_RX_DP = c[1];
      LP_RX_DN = c[0];
   endtask

   task automatic idle(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_word(logic [7:0] w);
      HS_RX_DATA   = w;
      HS_RXD_VALID = 1'b1;
      @(negedge clk);
      HS_RXD_VALID = 1'b0;
      HS_RX_DATA   = 8'($urandom);
   endtask

   task automatic wait_state(logic [2:0] st, int budget, string name);
      int k = 0;
      while (LANE_STATE !== st && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(name, LANE_STATE, st);
   endtask

   function automatic logic [7:0] rand_non_sync();
      logic [7:0] w;
      do w = 8'($urandom); while (w == SW);
      return w;
   endfunction

   // LP-11 -> LP-01 -> LP-00, then time the settle phase; returns in the first SYNC clock
   task automatic enter_sync();
      int k = 0;
      lp(2'b11);
      wait_state(3'd1, 12, "reach STOP");
      lp(2'b01);
      wait_state(3'd2, 12, "reach HS_RQST");
      lp(2'b00);
      while (HS_EN !== 1'b1 && k < 12) begin
         @(negedge clk);
         k++;
      end
      chk("HS_EN rises", HS_EN, 1);
      chk("state at HS_EN rise", LANE_STATE, 3);
      chk("RX_TERM_EN with HS_EN", RX_TERM_EN, 1);
      chk("LP_EN off in HS", LP_EN, 0);
      k = 0;
      while (LANE_STATE == 3'd3 && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk("settle clocks", k, SETTLE);
      chk("reach SYNC", LANE_STATE, 4);
   endtask

   task automatic run_burst(int nslip, int nw, bit lp_exit, bit fixed_pay);
      int         slips = 0;
      bit         done = 0;
      bit         err = 0;
      int         k;
      logic [7:0] w;
      enter_sync();
      // Leader search: compare words follow the rules match / slip (up to 7) / error
      for (int i = 0; !done; i++) begin
         w = (i < nslip) ? rand_non_sync() : SW;
         if (w == SW) begin
            push(EV_SOT, 8'h00);
            done = 1;
         end else if (slips < 7) begin
            push(EV_SLIP, 8'h00);
            slips++;
         end else begin
            push(EV_ERR, 8'h00);
            done = 1;
            err  = 1;
         end
         send_word(w);
         if (!done) begin
            idle($urandom_range(0, 2));
            send_word(($urandom_range(0, 1) == 1) ? SW : 8'($urandom));
            idle($urandom_range(0, 2));
         end
      end
      if (err) begin
         wait_state(3'd6, 4, "ERR after 8 misses");
         chk("enables off in ERR", {HS_EN, LP_EN, RX_TERM_EN}, 0);
         @(negedge clk);
         chk("IDLE after ERR", LANE_STATE, 0);
      end else begin
         chk("DATA after leader", LANE_STATE, 5);
         for (int j = 0; j < nw; j++) begin
            w = fixed_pay ? pay_q[j] : 8'($urandom);
            push(EV_DATA, w);
            send_word(w);
            if (j < nw - 1) idle($urandom_range(0, 5));
         end
         push(EV_EOT, 8'h00);
         if (lp_exit) begin
            lp(2'b11);
            wait_state(3'd0, 12, "IDLE after LP-11 exit");
         end else begin
            k = 0;
            do begin
               @(negedge clk);
               k++;
            end while (!EOT && k < 40);
            chk("idle clocks to EOT", k, EOT_TO);
            chk("IDLE after timeout", LANE_STATE, 0);
         end
         chk("HS_EN off after EOT", HS_EN, 0);
         chk("LP_EN back after EOT", LP_EN, 1);
      end
      idle(4);
      chk("burst events all seen", exp_q.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b0;
      PLL_LOCK = 1'b1;
      lp(2'b00);
      HS_RX_DATA = 8'h00;
      HS_RXD_VALID = 1'b0;
      idle(3);
      // Line activity while reset is held must not leak through
      HS_RXD_VALID = 1'b1;
      HS_RX_DATA = SW;
      lp(2'b11);
      @(negedge clk);
      chk("reset LANE_STATE", LANE_STATE, 0);
      chk("reset enables", {HS_EN, LP_EN, RX_TERM_EN}, 0);
      chk("reset pulses", {BITSLIP_ADJ, SOT, EOT, SOT_ERR, RX_DATA_VALID}, 0);
      chk("reset RX_DATA", RX_DATA, 0);
      HS_RXD_VALID = 1'b0;
      RST = 1'b1;
      @(negedge clk);
      chk("no STOP 1 clk after reset", LANE_STATE, 0);
      @(negedge clk);
      chk("no STOP 2 clk after reset", LANE_STATE, 0);
      wait_state(3'd1, 10, "STOP after LP-11");
      chk("LP_EN in STOP", LP_EN, 1);
      chk("HS_EN in STOP", HS_EN, 0);
      // Codes other than LP-01 keep STOP
      lp(2'b10);
      idle(8);
      chk("STOP holds on LP-10", LANE_STATE, 1);
      lp(2'b00);
      idle(8);
      chk("STOP holds on LP-00", LANE_STATE, 1);

      // Directed burst: payload 11, 22 closed by LP-11
      pay_q = {8'h11, 8'h22};
      run_burst(0, 2, 1, 1);
      // Leader found after 3 slips, timeout close
      run_burst(3, 3, 0, 0);
      // Eight misses: 7 slips then error
      run_burst(8, 0, 0, 0);

      // No words in SYNC: error after exactly SYNC_TIMEOUT clocks
      begin
         int k = 0;
         enter_sync();
         push(EV_ERR, 8'h00);
         while (LANE_STATE == 3'd4 && k < 300) begin
            @(negedge clk);
            k++;
         end
         chk("SYNC dwell clocks", k, SYNC_TO);
         chk("ERR after SYNC timeout", LANE_STATE, 6);
         idle(4);
         chk("sync timeout events seen", exp_q.size(), 0);
      end

      // LP-10 while requesting HS is an error
      lp(2'b11);
      wait_state(3'd1, 12, "reach STOP");
      lp(2'b01);
      wait_state(3'd2, 12, "reach HS_RQST");
      push(EV_ERR, 8'h00);
      lp(2'b10);
      wait_state(3'd6, 12, "ERR on LP-10");
      wait_state(3'd0, 4, "IDLE after LP-10 error");
      idle(3);
      chk("LP-10 events seen", exp_q.size(), 0);

      // PLL lock lost mid-burst
      begin
         logic [7:0] w;
         enter_sync();
         push(EV_SOT, 8'h00);
         send_word(SW);
         w = 8'($urandom);
         push(EV_DATA, w);
         send_word(w);
         idle(2);
         PLL_LOCK = 1'b0;
         @(negedge clk);
         chk("IDLE on PLL loss", LANE_STATE, 0);
         chk("enables off on PLL loss", {HS_EN, LP_EN, RX_TERM_EN}, 0);
         chk("RX_DATA held on PLL loss", RX_DATA, w);
         idle(5);
         chk("no EOT on PLL loss", exp_q.size(), 0);
         PLL_LOCK = 1'b1;
         idle(2);
         chk("LP_EN after relock", LP_EN, 1);
      end

      // Reset pulsed in SYNC drops HS enables at once
      enter_sync();
      idle(3);
      #2 RST = 1'b0;
      #1;
      chk("HS_EN off in reset", HS_EN, 0);
      chk("RX_TERM_EN off in reset", RX_TERM_EN, 0);
      chk("LANE_STATE in reset", LANE_STATE, 0);
      @(negedge clk);
      RST = 1'b1;
      idle(6);
      chk("no events after reset", exp_q.size(), 0);

      // A single-clock LP-11 glitch is not accepted
      lp(2'b11);
      @(negedge clk);
      lp(2'b00);
      idle(10);
      chk("glitch rejected", LANE_STATE, 0);

      for (int r = 0; r < 8; r++) begin
         run_burst($urandom_range(0, 8), $urandom_range(1, 6), 1'($urandom_range(0, 1)), 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
